// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: opcode values, branch_type encodings and FSM states for the MEM-stage controller
package mem_ctrl_pkg;
  localparam int OP_LW   = 2;
  localparam int OP_SW   = 3;
  localparam int OP_BEQ  = 4;
  localparam int OP_JUMP = 5;
  localparam int OP_LB   = 6;
  localparam int OP_SB   = 7;
  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_JUMP = 2'd1;
  localparam logic [1:0] BR_BEQ  = 2'd3;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;
endpackage

// File: rtl/mem_lane_fmt.sv
// mem_lane_fmt: byte-enable/write-data generation and load extraction for word and byte accesses
module mem_lane_fmt #(
  parameter int DATA_W = 32,
  localparam int LANES = DATA_W / 8,
  localparam int LB = $clog2(LANES)
) (
  input  logic              is_byte,
  input  logic [LB-1:0]     lane,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] rdata,
  output logic [LANES-1:0]  be,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data
);
  logic [7:0] rbyte;
  assign rbyte     = rdata[{lane, 3'b000} +: 8];
  assign be        = is_byte ? LANES'(1) << lane : '1;
  assign wdata     = is_byte ? {LANES{store_data[7:0]}} : store_data;
  assign load_data = is_byte ? {{(DATA_W-8){rbyte[7]}}, rbyte} : rdata;
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage decode plus a req/ack data-memory FSM with stall, timeout and misalignment reporting
module mem_stage_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int OP_MSB  = 31,
  parameter int OP_W    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  input  logic [31:0]         instruction,
  input  logic                alu_zero,
  input  logic [DATA_W-1:0]   addr_in,
  input  logic [DATA_W-1:0]   store_data,
  output logic [1:0]          branch_type,
  output logic                branch_taken,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [DATA_W-1:0]   load_data,
  output logic                load_valid,
  output logic                stall,
  output logic                mem_err
);
  localparam int LANES = DATA_W / 8;
  localparam int LB = $clog2(LANES);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [LANES-1:0] be_q, be_d;
  logic [LB-1:0] lane_q, lane_d;
  logic we_q, we_d, ld_q, ld_d, byte_q, byte_d, err_q, err_d;
  logic [OP_W-1:0] op;
  logic op_lw, op_sw, op_lb, op_sb, op_beq, op_jump;
  logic [LB-1:0] lane;
  logic in_idle, in_access, in_resp, go, misal, accept, timeout;
  logic fmt_byte;
  logic [LB-1:0] fmt_lane;
  logic [LANES-1:0] fmt_be;
  logic [DATA_W-1:0] fmt_wdata, fmt_load;
  logic unused_instr;
  assign op           = instruction[OP_MSB -: OP_W];
  assign unused_instr = ^instruction;
  assign op_lw        = op == OP_W'(OP_LW);
  assign op_sw        = op == OP_W'(OP_SW);
  assign op_lb        = op == OP_W'(OP_LB);
  assign op_sb        = op == OP_W'(OP_SB);
  assign op_beq       = op == OP_W'(OP_BEQ);
  assign op_jump      = op == OP_W'(OP_JUMP);
  assign lane         = addr_in[LB-1:0];
  assign in_idle      = state_q == S_IDLE;
  assign in_access    = state_q == S_ACCESS;
  assign in_resp      = state_q == S_RESP;
  assign go           = in_idle & instr_valid & ~rst;
  assign misal        = go & (op_lw | op_sw) & (lane != '0);
  assign accept       = go & (op_lw | op_sw | op_lb | op_sb) & ~misal;
  // ack on the final allowed cycle still wins over the timeout
  assign timeout      = in_access & ~mem_ack & (cnt_q == CNT_LAST);
  // one formatter serves both the request (IDLE, live inputs) and the response (RESP, latched lane)
  assign fmt_byte     = in_idle ? (op_lb | op_sb) : byte_q;
  assign fmt_lane     = in_idle ? lane : lane_q;
  mem_lane_fmt #(.DATA_W(DATA_W)) u_fmt (
    .is_byte    (fmt_byte),
    .lane       (fmt_lane),
    .store_data (store_data),
    .rdata      (rdata_q),
    .be         (fmt_be),
    .wdata      (fmt_wdata),
    .load_data  (fmt_load)
  );
  always_comb begin
    state_d = in_idle   ? (accept ? S_ACCESS : S_IDLE) :
              in_access ? (mem_ack ? (ld_q ? S_RESP : S_IDLE) : (timeout ? S_IDLE : S_ACCESS)) :
                          S_IDLE;
    cnt_d   = in_access ? cnt_q + CW'(1) : '0;
    err_d   = misal | timeout;
    rdata_d = (in_access & mem_ack & ld_q) ? mem_rdata : rdata_q;
    addr_d  = accept ? addr_in & ~DATA_W'(LANES - 1) : addr_q;
    we_d    = accept ? (op_sw | op_sb) : we_q;
    be_d    = accept ? fmt_be : be_q;
    wdata_d = accept ? fmt_wdata : wdata_q;
    ld_d    = accept ? (op_lw | op_lb) : ld_q;
    byte_d  = accept ? (op_lb | op_sb) : byte_q;
    lane_d  = accept ? lane : lane_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      ld_q    <= 1'b0;
      byte_q  <= 1'b0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      ld_q    <= ld_d;
      byte_q  <= byte_d;
      lane_q  <= lane_d;
    end
  end
  assign branch_type  = (instr_valid & ~rst) ? (op_jump ? BR_JUMP : op_beq ? BR_BEQ : BR_NONE) : BR_NONE;
  assign stall        = accept | (in_access & ~rst);
  assign branch_taken = instr_valid & ~rst & ~stall & (op_jump | (op_beq & alu_zero));
  assign mem_req      = in_access;
  assign mem_we       = we_q;
  assign mem_be       = be_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign load_valid   = in_resp;
  assign load_data    = in_resp ? fmt_load : '0;
  assign mem_err      = err_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: decode vector table, directed corner sequences and randomized transactions against a transaction-level model
module tb_mem_stage_ctrl;
  localparam int TIMEOUT = 15;
  logic clk = 0, rst = 1, instr_valid = 0, alu_zero = 0, mem_ack = 0;
  logic [31:0] instruction = 0, addr_in = 0, store_data = 0, mem_rdata = 0;
  logic [1:0] branch_type;
  logic branch_taken, mem_req, mem_we, load_valid, stall, mem_err;
  logic [3:0] mem_be;
  logic [31:0] mem_addr, mem_wdata, load_data;
  int checks = 0, errors = 0;
  logic [31:0] last_load, last_wdata;
  logic [3:0] last_be;

  mem_stage_ctrl #(.DATA_W(32), .OP_MSB(31), .OP_W(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction(instruction),
    .alu_zero(alu_zero), .addr_in(addr_in), .store_data(store_data),
    .branch_type(branch_type), .branch_taken(branch_taken), .mem_req(mem_req),
    .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .load_data(load_data),
    .load_valid(load_valid), .stall(stall), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] m_be(input bit byte_op, input int lane);
    return byte_op ? 4'(1 << lane) : 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input bit byte_op, input logic [31:0] sd);
    return byte_op ? 32'(sd[7:0]) * 32'h0101_0101 : sd;
  endfunction

  function automatic logic [31:0] m_load(input bit byte_op, input int lane, input logic [31:0] rd);
    int v;
    if (!byte_op) return rd;
    v = int'((rd >> (8 * lane)) & 32'hFF);
    if (v >= 128) v -= 256;
    return 32'(v);
  endfunction

  // d = number of ACCESS cycles without ack before the ack; d >= TIMEOUT means no ack at all
  task automatic txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                     input logic [31:0] rd, input int d);
    bit is_ld, is_st, byte_op, mem, mis, zero, etk;
    int lane, n;
    logic [1:0] ebt;
    is_ld   = (op == 2) || (op == 6);
    is_st   = (op == 3) || (op == 7);
    byte_op = (op == 6) || (op == 7);
    mem     = is_ld || is_st;
    lane    = int'(addr[1:0]);
    mis     = ((op == 2) || (op == 3)) && lane != 0;
    zero    = 1'($urandom);
    ebt     = (op == 5) ? 2'd1 : (op == 4) ? 2'd3 : 2'd0;
    etk     = (op == 5) || ((op == 4) && zero);
    instr_valid = 1; instruction = {op, 28'($urandom)}; addr_in = addr;
    store_data = sd; alu_zero = zero; mem_ack = 0;
    @(negedge clk);
    chk("accept_stall", stall, mem && !mis);
    chk("accept_btype", branch_type, ebt);
    chk("accept_taken", branch_taken, etk);
    chk("accept_req", mem_req, 0);
    step();
    if (!mem || mis) begin
      instr_valid = 0;
      @(negedge clk);
      chk("post_err", mem_err, mis);
      chk("post_req", mem_req, 0);
      chk("post_stall", stall, 0);
      step();
      return;
    end
    n = (d < TIMEOUT) ? d + 1 : TIMEOUT;
    for (int i = 0; i < n; i++) begin
      instr_valid = 1'($urandom); instruction = $urandom; addr_in = $urandom;
      store_data = $urandom; alu_zero = 1'($urandom);
      mem_ack = (d < TIMEOUT) && (i == d);
      mem_rdata = mem_ack ? rd : $urandom;
      @(negedge clk);
      chk("acc_req", mem_req, 1);
      chk("acc_stall", stall, 1);
      chk("acc_taken", branch_taken, 0);
      chk("acc_addr", mem_addr, {addr[31:2], 2'b00});
      chk("acc_be", mem_be, m_be(byte_op, lane));
      chk("acc_we", mem_we, is_st);
      if (is_st) chk("acc_wdata", mem_wdata, m_wdata(byte_op, sd));
      chk("acc_lv", load_valid, 0);
      chk("acc_err", mem_err, 0);
      last_be = mem_be; last_wdata = mem_wdata;
      step();
    end
    instr_valid = 0; mem_ack = 0;
    @(negedge clk);
    chk("end_req", mem_req, 0);
    chk("end_stall", stall, 0);
    chk("end_err", mem_err, d >= TIMEOUT);
    chk("end_lv", load_valid, is_ld && d < TIMEOUT);
    if (is_ld && d < TIMEOUT) chk("end_load", load_data, m_load(byte_op, lane, rd));
    last_load = load_data;
    step();
    @(negedge clk);
    chk("idle_lv", load_valid, 0);
    chk("idle_err", mem_err, 0);
    step();
  endtask

  typedef struct {
    logic v; logic [3:0] op; logic z; logic [1:0] bt; logic tk;
  } vec_t;
  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1, 4'd4, 1, 2'd3, 1};
    tbl[1]  = '{1, 4'd4, 0, 2'd3, 0};
    tbl[2]  = '{1, 4'd5, 1, 2'd1, 1};
    tbl[3]  = '{1, 4'd5, 0, 2'd1, 1};
    tbl[4]  = '{1, 4'd1, 1, 2'd0, 0};
    tbl[5]  = '{1, 4'd0, 1, 2'd0, 0};
    tbl[6]  = '{1, 4'd15, 1, 2'd0, 0};
    tbl[7]  = '{1, 4'd8, 0, 2'd0, 0};
    tbl[8]  = '{0, 4'd5, 1, 2'd0, 0};
    tbl[9]  = '{0, 4'd4, 1, 2'd0, 0};
    tbl[10] = '{0, 4'd2, 0, 2'd0, 0};

    step(); step();
    @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_lv", load_valid, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_load", load_data, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_btype", branch_type, 0);
    rst = 0;
    step();

    foreach (tbl[k]) begin
      instr_valid = tbl[k].v; instruction = {tbl[k].op, 28'h123_4567};
      alu_zero = tbl[k].z; addr_in = 32'h40;
      @(negedge clk);
      chk("tbl_btype", branch_type, tbl[k].bt);
      chk("tbl_taken", branch_taken, tbl[k].tk);
      chk("tbl_stall", stall, 0);
      step();
      @(negedge clk);
      chk("tbl_req", mem_req, 0);
    end
    instr_valid = 0;
    step();

    txn(4'd3, 32'h100, 32'hDEADBEEF, 32'h0, 1);
    txn(4'd6, 32'h103, 32'hFFFF_FFFF, 32'h8012_3456, 0);
    chk("lb_sext_const", last_load, 32'hFFFFFF80);
    txn(4'd7, 32'h101, 32'h0000_005A, 32'h0, 0);
    chk("sb_be_const", last_be, 4'b0010);
    chk("sb_wdata_const", last_wdata, 32'h5A5A5A5A);
    txn(4'd2, 32'h102, 32'h0, 32'h0, 0);
    txn(4'd2, 32'h300, 32'h0, 32'h1234_5678, TIMEOUT + 3);
    txn(4'd2, 32'h304, 32'h0, 32'hCAFE_F00D, TIMEOUT - 1);
    chk("lw_last_cycle_ack", last_load, 32'hCAFE_F00D);
    txn(4'd6, 32'h305, 32'h0, 32'h0000_7F00, TIMEOUT);
    txn(4'd6, 32'h305, 32'h0, 32'h0000_7F00, 2);
    chk("lb_pos_const", last_load, 32'h0000_007F);

    instr_valid = 1; instruction = {4'd2, 28'h0}; addr_in = 32'h200; mem_ack = 0;
    step();
    instr_valid = 0;
    step(); step();
    @(negedge clk);
    chk("rstacc_req_before", mem_req, 1);
    rst = 1; instr_valid = 1; instruction = {4'd5, 28'h0};
    step();
    @(negedge clk);
    chk("rstacc_req", mem_req, 0);
    chk("rstacc_stall", stall, 0);
    chk("rstacc_err", mem_err, 0);
    chk("rstacc_lv", load_valid, 0);
    chk("rstacc_load", load_data, 0);
    chk("rstacc_be", mem_be, 0);
    chk("rstacc_addr", mem_addr, 0);
    chk("rstacc_we", mem_we, 0);
    chk("rstacc_wdata", mem_wdata, 0);
    chk("rstacc_btype", branch_type, 0);
    chk("rstacc_taken", branch_taken, 0);
    rst = 0; instr_valid = 0; mem_ack = 1; mem_rdata = $urandom;
    step();
    @(negedge clk);
    chk("late_ack_req", mem_req, 0);
    chk("late_ack_lv", load_valid, 0);
    chk("late_ack_err", mem_err, 0);
    chk("late_ack_stall", stall, 0);
    mem_ack = 0;
    step();
    @(negedge clk);
    chk("late_ack_lv2", load_valid, 0);
    chk("late_ack_err2", mem_err, 0);
    step();

    for (int t = 0; t < 40; t++) begin
      int d;
      d = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 + int'($urandom_range(0, 1))
                                      : int'($urandom_range(0, 3));
      txn(4'($urandom_range(0, 8)), $urandom, $urandom, $urandom, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
